// File: rtl/dpsk_pkg.sv
// rtl/dpsk_pkg.sv - shared types, widths and saturating add for the DPSK receiver
package dpsk_pkg;

  localparam int SAMPLE_W    = 8;
  localparam int PROD_W      = 16;
  localparam int DEF_SYM_LEN = 200;
  localparam int ACC_MAX     = 33;

  typedef enum logic {IDLE, INTEG} state_t;

  typedef struct packed {
    logic                      sat;
    logic signed [ACC_MAX-1:0] sum;
  } sat_t;

  // Adds two sign-extended operands and clamps the result to a w-bit signed range.
  function automatic sat_t sat_add(input logic signed [ACC_MAX-1:0] a,
                                   input logic signed [ACC_MAX-1:0] b,
                                   input int unsigned               w);
    logic signed [ACC_MAX:0] s;
    logic signed [ACC_MAX:0] one;
    logic signed [ACC_MAX:0] hi;
    logic signed [ACC_MAX:0] lo;
    sat_t r;
    one = {{ACC_MAX{1'b0}}, 1'b1};
    s   = {a[ACC_MAX-1], a} + {b[ACC_MAX-1], b};
    hi  = (one <<< (w - 1)) - one;
    lo  = ~hi;
    r.sat = 1'b0;
    r.sum = s[ACC_MAX-1:0];
    if (s > hi) begin
      r.sat = 1'b1;
      r.sum = hi[ACC_MAX-1:0];
    end else if (s < lo) begin
      r.sat = 1'b1;
      r.sum = lo[ACC_MAX-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dpsk_demod_integrate_dump.sv
// rtl/dpsk_demod_integrate_dump.sv - product stage and saturating integrate-and-dump accumulator
module integrate_dump
  import dpsk_pkg::*;
#(
  parameter int ACC_W = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample,
  input  logic signed [SAMPLE_W-1:0] carrier,
  input  logic                       valid,
  input  logic                       first,
  input  logic                       last,
  output logic signed [ACC_W-1:0]    acc,
  output logic                       done,
  output logic                       ovf
);

  logic signed [PROD_W-1:0]  prod_q;
  logic                      vld_q;
  logic                      first_q;
  logic                      last_q;
  logic signed [ACC_MAX-1:0] acc_ext;
  logic signed [ACC_MAX-1:0] prod_ext;
  sat_t                      add_r;
  logic                      unused_hi;

  assign acc_ext   = ACC_MAX'(acc);
  assign prod_ext  = ACC_MAX'(prod_q);
  assign add_r     = sat_add(acc_ext, prod_ext, ACC_W);
  assign unused_hi = ^{add_r.sum[ACC_MAX-1:ACC_W]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q  <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      acc     <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      prod_q  <= sample * carrier;
      vld_q   <= valid;
      first_q <= valid & first;
      last_q  <= valid & last;
      done    <= vld_q & last_q;
      // A first-tagged product reloads, which also discards any abandoned partial sum.
      if (vld_q) begin
        if (first_q) begin
          acc <= ACC_W'(prod_q);
        end else begin
          acc <= add_r.sum[ACC_W-1:0];
          if (add_r.sat) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dpsk_demod.sv
// rtl/dpsk_demod.sv - coherent 2DPSK receiver: symbol timing, sign decision and differential decode
module dpsk_demod
  import dpsk_pkg::*;
#(
  parameter int SYM_LEN = DEF_SYM_LEN,
  parameter int ACC_W   = 24
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] rx_in,
  input  logic                       rx_valid,
  input  logic signed [SAMPLE_W-1:0] carrier_in,
  input  logic                       sym_start,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic signed [ACC_W-1:0]    sym_metric,
  output logic                       locked,
  output logic                       ovf
);

  localparam int CNT_W = $clog2(SYM_LEN);

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic                    prev_d;
  logic                    acc_valid;
  logic                    first;
  logic                    last;
  logic signed [ACC_W-1:0] acc;
  logic                    done;

  // sym_start wins over the natural boundary, so a start on the last sample abandons that symbol.
  always_comb begin
    acc_valid = 1'b0;
    first     = 1'b0;
    last      = 1'b0;
    if (rx_valid) begin
      if (sym_start) begin
        acc_valid = 1'b1;
        first     = 1'b1;
      end else if (state == INTEG) begin
        acc_valid = 1'b1;
        first     = (cnt == '0);
        last      = (cnt == CNT_W'(SYM_LEN - 1));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      locked <= 1'b0;
    end else if (rx_valid) begin
      if (sym_start) begin
        state  <= INTEG;
        locked <= 1'b1;
        cnt    <= CNT_W'(1);
      end else if (state == INTEG) begin
        cnt <= last ? '0 : cnt + 1'b1;
      end
    end
  end

  integrate_dump #(
    .ACC_W(ACC_W)
  ) u_integrate_dump (
    .clk    (clk),
    .rst_n  (rst_n),
    .sample (rx_in),
    .carrier(carrier_in),
    .valid  (acc_valid),
    .first  (first),
    .last   (last),
    .acc    (acc),
    .done   (done),
    .ovf    (ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      sym_metric <= '0;
      prev_d     <= 1'b0;
    end else begin
      bit_valid <= done;
      if (done) begin
        bit_out    <= ~acc[ACC_W-1] ^ prev_d;
        prev_d     <= ~acc[ACC_W-1];
        sym_metric <= acc;
      end
    end
  end

endmodule

// File: tb/tb_dpsk_demod.sv
// tb/tb_dpsk_demod.sv - randomized self-checking bench for dpsk_demod against a symbol-level model
module tb_dpsk_demod;

  logic              clk;
  logic              rst_n;
  logic signed [7:0] rx_in;
  logic              rx_valid;
  logic signed [7:0] carrier_in;
  logic              sym_start;
  logic              bo_a, bv_a, lk_a, ov_a;
  logic signed [23:0] sm_a;
  logic              bo_b, bv_b, lk_b, ov_b;
  logic signed [16:0] sm_b;

  dpsk_demod #(.SYM_LEN(8), .ACC_W(24)) u_a (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_valid(rx_valid), .carrier_in(carrier_in),
    .sym_start(sym_start), .bit_out(bo_a), .bit_valid(bv_a), .sym_metric(sm_a),
    .locked(lk_a), .ovf(ov_a)
  );

  dpsk_demod #(.SYM_LEN(16), .ACC_W(17)) u_b (
    .clk(clk), .rst_n(rst_n), .rx_in(rx_in), .rx_valid(rx_valid), .carrier_in(carrier_in),
    .sym_start(sym_start), .bit_out(bo_b), .bit_valid(bv_b), .sym_metric(sm_b),
    .locked(lk_b), .ovf(ov_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit     b;
    longint m;
    longint c;
  } exp_t;

  exp_t   exp_q[$];
  longint log_b[$];
  longint log_m[$];
  longint log_c[$];
  int     checks = 0;
  int     failures = 0;

  bit     sel;
  int     m_len, m_accw, m_idx;
  bit     m_locked, m_prev;
  longint m_sum;
  longint last_cyc, s1_last;
  int     exp_bits[5]    = '{1, 0, 1, 0, 1};
  longint exp_metric[5]  = '{80000, 80000, -80000, -80000, 80000};

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, want);
    end
  endtask

  // Symbol-level model: position within the symbol, clipped running sum, decision and XOR decode.
  task automatic model_step(input bit v, input int x, input int c, input bit ss);
    longint p, hi, lo;
    bit d;
    p  = longint'(x) * longint'(c);
    hi = (longint'(1) << (m_accw - 1)) - 1;
    lo = -(longint'(1) << (m_accw - 1));
    if (!v) return;
    if (ss) begin
      m_locked = 1'b1;
      m_sum    = p;
      m_idx    = 1;
      return;
    end
    if (!m_locked) return;
    if (m_idx == 0) begin
      m_sum = p;
      m_idx = 1;
    end else begin
      m_sum = m_sum + p;
      if (m_sum > hi) m_sum = hi;
      if (m_sum < lo) m_sum = lo;
      if (m_idx == m_len - 1) begin
        d = (m_sum >= 0);
        exp_q.push_back('{d ^ m_prev, m_sum, cyc + 3});
        m_prev = d;
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
  endtask

  task automatic drive(input bit v, input int x, input int c, input bit ss);
    @(posedge clk);
    #1;
    rx_valid   = v;
    rx_in      = x[7:0];
    carrier_in = c[7:0];
    sym_start  = ss;
    model_step(v, x, c, ss);
  endtask

  function automatic int rnd8();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, rnd8(), rnd8(), 1'b0);
  endtask

  task automatic send_sym(input bit ph, input bit ss, input int gap_at, input int gap_len, input int n);
    int carr;
    for (int i = 0; i < n; i++) begin
      if (i == gap_at)
        for (int g = 0; g < gap_len; g++) drive(1'b0, rnd8(), rnd8(), 1'b1);
      carr = (i % 2 == 0) ? 100 : -100;
      drive(1'b1, ph ? -carr : carr, carr, ss && (i == 0));
    end
    last_cyc = cyc;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    m_locked = 1'b0;
    m_idx    = 0;
    m_sum    = 0;
    m_prev   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      rx_valid   = 1'($urandom_range(0, 1));
      sym_start  = 1'($urandom_range(0, 1));
      rx_in      = 8'($urandom_range(0, 255));
      carrier_in = 8'($urandom_range(0, 255));
    end
    #1;
    chk("rst_flags_a", {bo_a, bv_a, lk_a, ov_a}, 0);
    chk("rst_metric_a", sm_a, 0);
    chk("rst_flags_b", {bo_b, bv_b, lk_b, ov_b}, 0);
    chk("rst_metric_b", sm_b, 0);
    @(posedge clk);
    #3;
    rx_valid  = 1'b0;
    sym_start = 1'b0;
    rst_n     = 1'b1;
  endtask

  task automatic clear_log();
    log_b.delete();
    log_m.delete();
    log_c.delete();
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].c < cyc) begin
        chk("missed_strobe", 0, exp_q[0].c);
        void'(exp_q.pop_front());
      end
      if (sel ? bv_b : bv_a) begin
        logic signed [63:0] met;
        logic               bo;
        exp_t               e;
        met = sel ? 64'(sm_b) : 64'(sm_a);
        bo  = sel ? bo_b : bo_a;
        log_b.push_back(longint'(bo));
        log_m.push_back(met);
        log_c.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", cyc, -1);
        end else begin
          e = exp_q.pop_front();
          chk("model_bit", bo, e.b);
          chk("model_metric", met, e.m);
          chk("model_strobe_cycle", cyc, e.c);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; rx_valid = 1'b0; sym_start = 1'b0; rx_in = '0; carrier_in = '0;
    sel = 1'b0; m_len = 8; m_accw = 24;
    m_locked = 1'b0; m_idx = 0; m_sum = 0; m_prev = 1'b0;
    do_reset();

    for (int i = 0; i < 20; i++) drive(1'b1, rnd8(), rnd8(), 1'b0);
    #1;
    chk("locked_before_start", lk_a, 0);

    send_sym(1'b0, 1'b1, -1, 0, 8);
    do_reset();

    clear_log();
    send_sym(1'b0, 1'b1, -1, 0, 8);
    s1_last = last_cyc;
    send_sym(1'b0, 1'b0, -1, 0, 8);
    send_sym(1'b1, 1'b0, -1, 0, 8);
    send_sym(1'b1, 1'b0, -1, 0, 8);
    send_sym(1'b0, 1'b0, -1, 0, 8);
    idle(6);
    chk("locked_after_start", lk_a, 1);
    chk("phase_strobes", log_c.size(), 5);
    if (log_c.size() == 5) begin
      chk("latency_sym1", log_c[0], s1_last + 3);
      for (int i = 0; i < 5; i++) begin
        chk("phase_bit", log_b[i], exp_bits[i]);
        chk("phase_metric", log_m[i], exp_metric[i]);
      end
      for (int i = 0; i < 4; i++) chk("b2b_spacing", log_c[i+1] - log_c[i], 8);
    end

    do_reset();
    clear_log();
    send_sym(1'b0, 1'b1, -1, 0, 8);
    send_sym(1'b0, 1'b0, 3, 3, 8);
    send_sym(1'b1, 1'b0, -1, 0, 8);
    send_sym(1'b1, 1'b0, -1, 0, 8);
    send_sym(1'b0, 1'b0, -1, 0, 8);
    idle(6);
    chk("gap_strobes", log_c.size(), 5);
    if (log_c.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("gap_bit", log_b[i], exp_bits[i]);
        chk("gap_metric", log_m[i], exp_metric[i]);
      end
      chk("gap_delay", log_c[1] - log_c[0], 11);
      chk("gap_after", log_c[2] - log_c[1], 8);
    end

    do_reset();
    clear_log();
    send_sym(1'b0, 1'b1, -1, 0, 8);
    send_sym(1'b0, 1'b0, -1, 0, 8);
    send_sym(1'b1, 1'b0, -1, 0, 4);
    send_sym(1'b0, 1'b1, -1, 0, 8);
    send_sym(1'b1, 1'b0, -1, 0, 8);
    idle(6);
    chk("resync_strobes", log_c.size(), 4);
    if (log_c.size() == 4) begin
      chk("resync_spacing", log_c[2] - log_c[1], 12);
      chk("resync_bit_prev_kept", log_b[2], 0);
      chk("resync_bit_next", log_b[3], 1);
    end

    do_reset();
    clear_log();
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 9) != 0, rnd8(), rnd8(), (i == 0) || ($urandom_range(0, 49) == 0));
    idle(6);
    chk("rand_pending", exp_q.size(), 0);
    chk("rand_strobes_seen", log_c.size() > 50, 1);
    chk("ovf_clear_24b", ov_a, 0);

    sel = 1'b1; m_len = 16; m_accw = 17;
    do_reset();
    clear_log();
    chk("ovf_after_reset", ov_b, 0);
    for (int s = 0; s < 3; s++)
      for (int i = 0; i < 16; i++) drive(1'b1, 127, -128, (s == 0) && (i == 0));
    idle(6);
    chk("sat_strobes", log_c.size(), 3);
    if (log_c.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("sat_metric", log_m[i], -65536);
        chk("sat_bit", log_b[i], 0);
      end
    end
    chk("sat_ovf", ov_b, 1);
    idle(20);
    #1;
    chk("sat_ovf_sticky", ov_b, 1);

    chk("pending_end", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
